// File: rtl/muldiv_pkg.sv
// RV32M multiply-group constants, decoded-op bundle and shared decoder.
// Imported by sync_fifo users and the muldiv_issue_ctrl top.
package muldiv_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;
   localparam logic [2:0] F3_MUL     = 3'b000;
   localparam logic [2:0] F3_MULH    = 3'b001;
   localparam logic [2:0] F3_MULHSU  = 3'b010;
   localparam logic [2:0] F3_MULHU   = 3'b011;

   typedef struct packed {
      logic signed_a;
      logic signed_b;
      logic upper;
      logic legal;
   } dec_op_t;

   function automatic dec_op_t decode(input logic [31:0] instr);
      dec_op_t    d;
      logic [2:0] f3;
      f3 = instr[14:12];
      d.legal    = (instr[6:0] == OPC_OP) &&
                   (instr[31:25] == F7_MULDIV) && !f3[2];
      d.signed_a = (f3 == F3_MULH) || (f3 == F3_MULHSU);
      d.signed_b = (f3 == F3_MULH);
      d.upper    = (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
                   (f3 == F3_MULHU);
      return d;
   endfunction

endpackage

// File: rtl/muldiv_issue_ctrl_fifo.sv
// Synchronous FIFO with wrapping pointers and separate occupancy count.
// Callers never push when full or pop when empty.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign rdata = mem[rd_ptr];

   // Storage array; contents are don't-care until counted valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// RV32M multiply issue front-end: decode, issue, in-order tagged responses.
// Optional macro MULDIV_RSP_BYPASS_EN: same-cycle result bypass to response.
module muldiv_issue_ctrl
   import muldiv_pkg::*;
#(
   parameter int TAG_W          = 4,
   parameter int DEPTH          = 8,
   parameter int MULT_PIPELINED = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [31:0]      req_instr_i,
   input  logic [31:0]      req_rs1_i,
   input  logic [31:0]      req_rs2_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_result_o,
   output logic [TAG_W-1:0] rsp_tag_o,
   output logic             rsp_illegal_o,
   output logic             mult_en_o,
   output logic [31:0]      op_A_o,
   output logic [31:0]      op_B_o,
   output logic             signed_A_o,
   output logic             signed_B_o,
   output logic             upper_o,
   input  logic [31:0]      mult_result_i,
   input  logic             mult_done_i,
   output logic             err_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   dec_op_t          dec;
   logic             req_fire;
   logic             rsp_fire;
   logic [CW-1:0]    outstanding;
   logic [CW-1:0]    tag_cnt;
   logic [CW-1:0]    data_cnt;
   logic [TAG_W:0]   tag_head;
   logic [31:0]      data_head;
   logic             head_ill;
   logic             tag_ne;
   logic             data_ne;
   logic             done_ok;
   logic             byp;
   logic             data_push;
   logic             data_pop;
   logic             issue_ok;

   assign dec      = decode(req_instr_i);
   assign head_ill = tag_head[0];
   assign tag_ne   = (tag_cnt != '0);
   assign data_ne  = (data_cnt != '0);
   assign done_ok  = mult_done_i && (outstanding != '0);

   // Non-pipelined multiplier: hold off while an op is queued or in flight.
   assign issue_ok = (MULT_PIPELINED != 0) ||
                     ((outstanding == '0) && !mult_en_o);
   assign req_ready_o = !rst_i && (tag_cnt < CW'(DEPTH)) && issue_ok;
   assign req_fire    = req_valid_i && req_ready_o;

`ifdef MULDIV_RSP_BYPASS_EN
   assign byp = done_ok && tag_ne && !head_ill && !data_ne;
`else
   assign byp = 1'b0;
`endif

   assign rsp_valid_o = tag_ne && (head_ill || data_ne || byp);
   assign rsp_fire    = rsp_valid_o && rsp_ready_i;
   assign data_push   = done_ok && !(byp && rsp_ready_i);
   assign data_pop    = rsp_fire && !head_ill && !byp;

   // Response fields are forced to zero whenever no response is presented.
   always_comb begin
      rsp_result_o  = '0;
      rsp_tag_o     = '0;
      rsp_illegal_o = 1'b0;
      if (rsp_valid_o) begin
         rsp_tag_o     = tag_head[TAG_W:1];
         rsp_illegal_o = head_ill;
         if (!head_ill) rsp_result_o = byp ? mult_result_i : data_head;
      end
   end

   sync_fifo #(.W(TAG_W + 1), .DEPTH(DEPTH)) u_tag_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (req_fire),
      .wdata ({req_tag_i, !dec.legal}),
      .pop   (rsp_fire),
      .rdata (tag_head),
      .count (tag_cnt)
   );

   sync_fifo #(.W(32), .DEPTH(DEPTH)) u_data_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (data_push),
      .wdata (mult_result_i),
      .pop   (data_pop),
      .rdata (data_head),
      .count (data_cnt)
   );

   // Register operands/mode and fire a one-cycle issue pulse for legal ops.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mult_en_o  <= 1'b0;
         op_A_o     <= '0;
         op_B_o     <= '0;
         signed_A_o <= 1'b0;
         signed_B_o <= 1'b0;
         upper_o    <= 1'b0;
      end else begin
         mult_en_o <= req_fire && dec.legal;
         if (req_fire && dec.legal) begin
            op_A_o     <= req_rs1_i;
            op_B_o     <= req_rs2_i;
            signed_A_o <= dec.signed_a;
            signed_B_o <= dec.signed_b;
            upper_o    <= dec.upper;
         end
      end
   end

   // Track issued-but-unfinished ops; flag done pulses nobody asked for.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outstanding <= '0;
         err_o       <= 1'b0;
      end else begin
         case ({mult_en_o, done_ok})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (mult_done_i && (outstanding == '0)) err_o <= 1'b1;
      end
   end

endmodule
